// File: rtl/fsic_tx_phase_serializer.sv
// fsic_tx_phase_serializer
// Locks onto the coreclk phase index supplied by the phase counter stage and,
// once locked, splits each coreclk-rate parallel word into pCLK_RATIO serial
// slices, one per ioclk cycle, with slice 0 emitted first.
// Optional feature macro: FSIC_TX_PHASE_ERR_CNT_EN. When it is defined,
// phase_err_cnt is a saturating count of lock losses. When it is undefined,
// phase_err_cnt is tied to zero and no counter is built.
module fsic_tx_phase_serializer #(
    parameter int pCLK_RATIO    = 4,
    parameter int pSERIAL_WIDTH = 12,
    parameter int pLOCK_CNT     = 4
) (
    input  logic                                  ioclk,
    input  logic                                  axis_rst_n,
    input  logic [$clog2(pCLK_RATIO)-1:0]         phase_cnt_in,
    input  logic [pCLK_RATIO*pSERIAL_WIDTH-1:0]   txdata_in,
    input  logic                                  txvalid_in,
    output logic                                  txdata_ack,
    output logic [pSERIAL_WIDTH-1:0]              serial_txd,
    output logic                                  serial_txv,
    output logic                                  phase_locked,
    output logic [7:0]                            phase_err_cnt
);

    localparam int PH_W = $clog2(pCLK_RATIO);
    localparam int GC_W = $clog2(pLOCK_CNT) + 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(pCLK_RATIO - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(pLOCK_CNT - 1);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                                state, state_nxt;
    logic [PH_W-1:0]                       exp_phase, exp_phase_nxt;
    logic [GC_W-1:0]                       good_cnt, good_cnt_nxt;
    logic [pCLK_RATIO*pSERIAL_WIDTH-1:0]   shreg;
    logic [pSERIAL_WIDTH-1:0]              slice_sel;
    logic                                  match;
    logic                                  load_edge;
    logic                                  shift_edge;
`ifdef FSIC_TX_PHASE_ERR_CNT_EN
    logic                                  lock_lost;
    logic [7:0]                            err_cnt;
`endif

    assign match      = (phase_cnt_in == exp_phase);
    assign load_edge  = (state == LOCKED) && match && (phase_cnt_in == '0);
    assign shift_edge = (state == LOCKED) && match && (phase_cnt_in != '0);

    // State, expected phase and wrap counter registers
    always_ff @(posedge ioclk) begin
        if (!axis_rst_n) begin
            state     <= UNLOCK;
            exp_phase <= '0;
            good_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            exp_phase <= exp_phase_nxt;
            good_cnt  <= good_cnt_nxt;
        end
    end

    // Next-state decode: acquire phase, count clean wraps, drop lock on any slip
    always_comb begin
        state_nxt     = state;
        exp_phase_nxt = exp_phase;
        good_cnt_nxt  = good_cnt;
`ifdef FSIC_TX_PHASE_ERR_CNT_EN
        lock_lost     = 1'b0;
`endif
        case (state)
            UNLOCK: begin
                // Take whatever phase is presented as the new reference.
                exp_phase_nxt = phase_cnt_in + PH_W'(1);
                good_cnt_nxt  = '0;
                state_nxt     = TRACK;
            end
            TRACK: begin
                if (!match) begin
                    state_nxt = UNLOCK;
                end else begin
                    exp_phase_nxt = exp_phase + PH_W'(1);
                    if (phase_cnt_in == PH_LAST) begin
                        if (good_cnt == GC_LAST) begin
                            state_nxt = LOCKED;
                        end else begin
                            good_cnt_nxt = good_cnt + GC_W'(1);
                        end
                    end
                end
            end
            LOCKED: begin
                if (match) begin
                    exp_phase_nxt = exp_phase + PH_W'(1);
                end else begin
                    state_nxt = UNLOCK;
`ifdef FSIC_TX_PHASE_ERR_CNT_EN
                    lock_lost = 1'b1;
`endif
                end
            end
            default: begin
                state_nxt = UNLOCK;
            end
        endcase
    end

    // Slice mux over the held word, indexed by the current phase
    always_comb begin
        slice_sel = '0;
        for (int k = 0; k < pCLK_RATIO; k++) begin
            if (phase_cnt_in == PH_W'(k)) begin
                slice_sel = shreg[k*pSERIAL_WIDTH +: pSERIAL_WIDTH];
            end
        end
    end

    // Serial output: load at phase 0, walk slices after, blank when not locked
    always_ff @(posedge ioclk) begin
        if (!axis_rst_n) begin
            shreg      <= '0;
            serial_txd <= '0;
            serial_txv <= 1'b0;
            txdata_ack <= 1'b0;
        end else if (load_edge) begin
            shreg      <= txdata_in;
            serial_txd <= txdata_in[pSERIAL_WIDTH-1:0];
            serial_txv <= txvalid_in;
            txdata_ack <= txvalid_in;
        end else if (shift_edge) begin
            serial_txd <= slice_sel;
            txdata_ack <= 1'b0;
        end else begin
            // A word interrupted by lock loss is dropped, never resumed.
            serial_txd <= '0;
            serial_txv <= 1'b0;
            txdata_ack <= 1'b0;
        end
    end

    // Lock indicator mirrors the state register exactly
    always_ff @(posedge ioclk) begin
        if (!axis_rst_n) begin
            phase_locked <= 1'b0;
        end else begin
            phase_locked <= (state_nxt == LOCKED);
        end
    end

`ifdef FSIC_TX_PHASE_ERR_CNT_EN
    // Saturating count of LOCKED -> UNLOCK transitions
    always_ff @(posedge ioclk) begin
        if (!axis_rst_n) begin
            err_cnt <= 8'h00;
        end else if (lock_lost && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign phase_err_cnt = err_cnt;
`else
    assign phase_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fsic_tx_phase_serializer.sv
// Testbench for fsic_tx_phase_serializer: directed phase/data vectors, each
// with hand-computed expected outputs pushed into a scoreboard queue; an
// independent monitor pops one entry per ioclk edge and compares.
module tb_fsic_tx_phase_serializer;

`ifdef FSIC_TX_PHASE_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        ioclk = 1'b0;
    logic        axis_rst_n;
    logic [1:0]  phase_cnt_in;
    logic [47:0] txdata_in;
    logic        txvalid_in;
    logic        txdata_ack;
    logic [11:0] serial_txd;
    logic        serial_txv;
    logic        phase_locked;
    logic [7:0]  phase_err_cnt;

    typedef struct packed {
        logic [11:0] txd;
        logic        txv;
        logic        ack;
        logic        lock;
        logic [7:0]  err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_edge   = 0;

    always #5 ioclk = ~ioclk;

    fsic_tx_phase_serializer #(
        .pCLK_RATIO   (4),
        .pSERIAL_WIDTH(12),
        .pLOCK_CNT    (4)
    ) dut (
        .ioclk        (ioclk),
        .axis_rst_n   (axis_rst_n),
        .phase_cnt_in (phase_cnt_in),
        .txdata_in    (txdata_in),
        .txvalid_in   (txvalid_in),
        .txdata_ack   (txdata_ack),
        .serial_txd   (serial_txd),
        .serial_txv   (serial_txv),
        .phase_locked (phase_locked),
        .phase_err_cnt(phase_err_cnt)
    );

    function automatic logic [7:0] err_exp(input int n);
        if (!ERR_EN) return 8'h00;
        return (n > 255) ? 8'hFF : 8'(n);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, n_edge, got, want);
        end
    endtask

    // One ioclk cycle of stimulus plus the outputs expected after its edge
    task automatic drive(input int ph, input logic [47:0] d, input logic v, input logic rn,
                         input logic [11:0] etxd, input logic etxv, input logic eack,
                         input logic elock, input logic [7:0] eerr);
        exp_t e;
        @(negedge ioclk);
        phase_cnt_in = 2'(ph);
        txdata_in    = d;
        txvalid_in   = v;
        axis_rst_n   = rn;
        e.txd  = etxd;
        e.txv  = etxv;
        e.ack  = eack;
        e.lock = elock;
        e.err  = eerr;
        exp_q.push_back(e);
    endtask

    // UNLOCK edge at phase 3, then four clean wraps; lock appears on the last edge
    task automatic relock(input int errs);
        drive(3, 48'h0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, err_exp(errs));
        for (int w = 0; w < 4; w++) begin
            for (int p = 0; p < 4; p++) begin
                drive(p, 48'h0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0,
                      (w == 3) && (p == 3), err_exp(errs));
            end
        end
    endtask

    // One full locked coreclk period carrying word d
    task automatic send_word(input logic [47:0] d, input logic v, input int errs);
        for (int p = 0; p < 4; p++) begin
            drive(p, d, v, 1'b1, d[p*12 +: 12], v, v && (p == 0), 1'b1, err_exp(errs));
        end
    endtask

    // Monitor: compare one scoreboard entry per edge, sampled 1 time unit after it
    initial begin
        forever begin
            @(posedge ioclk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("serial_txd",    32'(serial_txd),    32'(mon_e.txd));
                chk("serial_txv",    32'(serial_txv),    32'(mon_e.txv));
                chk("txdata_ack",    32'(txdata_ack),    32'(mon_e.ack));
                chk("phase_locked",  32'(phase_locked),  32'(mon_e.lock));
                chk("phase_err_cnt", 32'(phase_err_cnt), 32'(mon_e.err));
                n_edge++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, edge=%0d", n_edge);
        $fatal(1, "timeout");
    end

    initial begin
        axis_rst_n   = 1'b0;
        phase_cnt_in = 2'd0;
        txdata_in    = 48'h0;
        txvalid_in   = 1'b0;

        // Reset holds every output at zero even with live-looking inputs
        for (int i = 0; i < 3; i++) begin
            drive(i, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'h00);
        end

        // Acquire lock from reset; serial_txd stays zero throughout
        relock(0);

        // Valid word, slices low to high, single ack
        send_word(48'hABC_DEF_123_456, 1'b1, 0);
        // Invalid word: slices still walk, but no valid and no ack
        send_word(48'h111_222_333_444, 1'b0, 0);

        // Phase slip 0,1,3 mid-word drops the word and the lock
        drive(0, 48'h012_345_678_9AB, 1'b1, 1'b1, 12'h9AB, 1'b1, 1'b1, 1'b1, err_exp(0));
        drive(1, 48'h012_345_678_9AB, 1'b1, 1'b1, 12'h678, 1'b1, 1'b0, 1'b1, err_exp(0));
        drive(3, 48'h012_345_678_9AB, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, err_exp(1));
        relock(1);

        // Reset during slice 2 aborts the word and clears the error count
        drive(0, 48'hFED_CBA_987_654, 1'b1, 1'b1, 12'h654, 1'b1, 1'b1, 1'b1, err_exp(1));
        drive(1, 48'hFED_CBA_987_654, 1'b1, 1'b1, 12'h987, 1'b1, 1'b0, 1'b1, err_exp(1));
        drive(2, 48'hFED_CBA_987_654, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'h00);
        relock(0);
        send_word(48'h5A5_A5A_0F0_F0F, 1'b1, 0);

        // Repeated lock losses drive the error count into saturation
        for (int i = 1; i <= 300; i++) begin
            drive(1, 48'h0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, err_exp(i));
            relock(i);
        end
        drive(1, 48'h0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, err_exp(301));

        repeat (3) @(negedge ioclk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fsic_tx_phase_serializer.md
FSIC_TX_PHASE_SERIALIZER -- requirements
Module: fsic_tx_phase_serializer

Interface
REQ-001 Parameter pCLK_RATIO, default 4, ioclk cycles per coreclk cycle; SHALL be a power of two, >= 2.
REQ-002 Parameter pSERIAL_WIDTH, default 12, width of one serial slice.
REQ-003 Parameter pLOCK_CNT, default 4, consecutive clean phase wraps required for lock.
REQ-004 ioclk  input  1  sole clock; every flop SHALL update on its rising edge.
REQ-005 axis_rst_n  input  1  reset, synchronous, active-low.
REQ-006 phase_cnt_in  input  $clog2(pCLK_RATIO)  coreclk phase index from the phase counter stage.
REQ-007 txdata_in  input  pCLK_RATIO*pSERIAL_WIDTH  parallel word, stable for a full coreclk period.
REQ-008 txvalid_in  input  1  txdata_in qualifier.
REQ-009 txdata_ack  output  1  one-cycle pulse: word accepted.
REQ-010 serial_txd  output  pSERIAL_WIDTH  serialized slice.
REQ-011 serial_txv  output  1  serial_txd qualifier.
REQ-012 phase_locked  output  1  high while FSM is in LOCKED.
REQ-013 phase_err_cnt  output  8  saturating count of lost locks.

Function
REQ-014 exp_phase register SHALL hold the expected phase_cnt_in value; match = (phase_cnt_in == exp_phase).
REQ-015 FSM states: UNLOCK, TRACK, LOCKED; every transition takes effect on the next ioclk edge.
REQ-016 UNLOCK: exp_phase <= phase_cnt_in+1 (mod pCLK_RATIO), good_cnt <= 0, go to TRACK unconditionally.
REQ-017 TRACK: mismatch -> UNLOCK; match -> exp_phase <= exp_phase+1 (mod pCLK_RATIO); match with phase_cnt_in == pCLK_RATIO-1 -> good_cnt+1, and when good_cnt == pLOCK_CNT-1 go to LOCKED instead.
REQ-018 LOCKED: match -> exp_phase increments and state holds; mismatch -> UNLOCK and phase_err_cnt increments.
REQ-019 phase_locked SHALL be a registered decode of state == LOCKED.
REQ-020 Load edge: state LOCKED, match, phase_cnt_in == 0; shreg <= txdata_in, serial_txd <= txdata_in[pSERIAL_WIDTH-1:0], serial_txv <= txvalid_in, txdata_ack <= txvalid_in.
REQ-021 Other LOCKED matching edges: serial_txd <= shreg[phase_cnt_in*pSERIAL_WIDTH +: pSERIAL_WIDTH]; serial_txv holds; txdata_ack <= 0.
REQ-022 Latency: one ioclk edge from phase_cnt_in sample to the corresponding serial_txd slice; slice k emitted for phase k, slice 0 first.
REQ-023 Any edge not in LOCKED, or any mismatching edge: serial_txd <= 0, serial_txv <= 0, txdata_ack <= 0; a word partially sent at lock loss is dropped, not resumed.
REQ-024 txvalid_in low at load edge: serial_txv low for that whole coreclk period, no ack.
REQ-025 phase_err_cnt SHALL saturate at 8'hFF.

Reset
REQ-026 When axis_rst_n is low at an ioclk edge: state <= UNLOCK, exp_phase <= 0, good_cnt <= 0, shreg <= 0, serial_txd <= 0, serial_txv <= 0, txdata_ack <= 0, phase_locked <= 0, phase_err_cnt <= 0.
REQ-027 Reset asserted mid-word SHALL abort the word; after release, relock takes a minimum of pLOCK_CNT full wraps.

Configuration
REQ-028 Macro FSIC_TX_PHASE_ERR_CNT_EN defined: phase_err_cnt implemented per REQ-018/REQ-025.
REQ-029 Macro FSIC_TX_PHASE_ERR_CNT_EN undefined: no counter flops; phase_err_cnt tied to 8'h00; all other behaviour identical.

Verification
REQ-030 Clean phase 0,1,2,3 repeating from reset release -> phase_locked rises after 4 full wraps plus FSM latency; serial_txd stays 0 until then.
REQ-031 Locked, txdata_in=48'hABC_DEF_123_456, txvalid_in=1 -> serial_txd 12'h456,12'h123,12'hDEF,12'hABC on successive edges, serial_txv=1, one txdata_ack pulse.
REQ-032 Locked, phase sequence 0,1,3 -> next edge serial_txv=0 and phase_locked=0; phase_err_cnt=1 (macro on) or 0 (macro off).
REQ-033 Locked, txvalid_in=0 at phase 0 -> serial_txv=0 for 4 edges, txdata_ack never asserts.
REQ-034 axis_rst_n low for 1 edge during slice 2 -> all outputs 0 on next edge; relock after 4 clean wraps.
REQ-035 Force 300 lock losses with macro on -> phase_err_cnt holds 8'hFF.
